trap_unit: RTL and testbench

TRAP_UNIT -- requirements
Module: trap_unit

---
 rtl/trap_unit.sv | 141 ++++++++++++++
 tb/tb_trap_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// Machine-mode trap/interrupt unit: owns the trap CSRs, picks the highest-priority
// MEM-stage event and issues a one-cycle flush/redirect request to the pipeline.
module trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid_mem,
    input  logic [31:0] pc_mem,
    input  logic        ecall_mem,
    input  logic        ebreak_mem,
    input  logic        illegal_mem,
    input  logic        mret_mem,
    input  logic        timer_irq,
    input  logic        ext_irq,
    input  logic        stall_pipl,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic        mret_exec,
    output logic [31:0] redirect_pc,
    output logic        o_dbg_state
);

    typedef enum logic {ST_RUN = 1'b0, ST_SETTLE = 1'b1} state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      r_state;
    logic        r_sync1, r_sync2;
    logic        r_mie, r_mpie;       // mstatus.MIE / mstatus.MPIE
    logic        r_mtie, r_meie;      // mie.MTIE / mie.MEIE
    logic [31:0] r_mtvec, r_mepc, r_mcause;

    logic        w_active, w_ext_take, w_tmr_take;
    logic        w_trap, w_mret;
    logic [31:0] w_cause, w_epc;

    assign o_dbg_state = r_state;

    // trap_taken / mret_exec are single-cycle requests, valid only in RUN and
    // never together; redirect_pc is meaningful only while one of them is high.
    always_comb begin
        w_active   = (r_state == ST_RUN) && !stall_pipl && instr_valid_mem;
        w_ext_take = r_mie & r_meie & r_sync2;
        w_tmr_take = r_mie & r_mtie & timer_irq;
        w_trap     = 1'b0;
        w_mret     = 1'b0;
        w_cause    = 32'h0;
        w_epc      = pc_mem;
        if (w_active) begin
            if (illegal_mem) begin
                w_trap  = 1'b1;
                w_cause = 32'd2;
            end else if (ecall_mem) begin
                w_trap  = 1'b1;
                w_cause = 32'd11;
            end else if (ebreak_mem) begin
                w_trap  = 1'b1;
                w_cause = 32'd3;
            end else if (mret_mem) begin
                w_mret  = 1'b1;
            end else if (w_ext_take) begin
                w_trap  = 1'b1;
                w_cause = 32'h8000_000B;
                w_epc   = pc_mem + 32'd4;
            end else if (w_tmr_take) begin
                w_trap  = 1'b1;
                w_cause = 32'h8000_0007;
                w_epc   = pc_mem + 32'd4;
            end
        end
    end

    assign trap_taken  = w_trap & ~reset;
    assign mret_exec   = w_mret & ~reset;
    assign redirect_pc = trap_taken ? r_mtvec : (mret_exec ? r_mepc : 32'h0);

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            12'h300: csr_rdata = {24'h0, r_mpie, 3'b000, r_mie, 3'b000};
            12'h304: csr_rdata = {20'h0, r_meie, 3'b000, r_mtie, 7'h00};
            12'h305: csr_rdata = r_mtvec;
            12'h341: csr_rdata = r_mepc;
            12'h342: csr_rdata = r_mcause;
            default: csr_rdata = 32'h0;
        endcase
    end

    // Trap/mret updates come after the CSR write so they take precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mtie   <= 1'b0;
            r_meie   <= 1'b0;
            r_mtvec  <= RESET_MTVEC & ALIGN_MASK;
            r_mepc   <= 32'h0;
            r_mcause <= 32'h0;
        end else begin
            r_sync1 <= ext_irq;
            r_sync2 <= r_sync1;
            if (csr_we) begin
                case (csr_addr)
                    12'h300: begin
                        r_mie  <= csr_wdata[3];
                        r_mpie <= csr_wdata[7];
                    end
                    12'h304: begin
                        r_mtie <= csr_wdata[7];
                        r_meie <= csr_wdata[11];
                    end
                    12'h305: r_mtvec  <= csr_wdata & ALIGN_MASK;
                    12'h341: r_mepc   <= csr_wdata & ALIGN_MASK;
                    12'h342: r_mcause <= csr_wdata;
                    default: ;
                endcase
            end
            if (w_trap) begin
                r_mepc   <= w_epc & ALIGN_MASK;
                r_mcause <= w_cause;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
                r_state  <= ST_SETTLE;
            end else if (w_mret) begin
                r_mie    <= r_mpie;
                r_mpie   <= 1'b1;
                r_state  <= ST_SETTLE;
            end else if (!stall_pipl) begin
                r_state  <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_trap_unit.sv
// Bench for trap_unit: directed scenarios plus random traffic, all outputs
// compared every cycle against a CSR-level reference model.
module tb_trap_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid_mem;
    logic [31:0] pc_mem;
    logic        ecall_mem, ebreak_mem, illegal_mem, mret_mem;
    logic        timer_irq, ext_irq, stall_pipl;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        trap_taken, mret_exec;
    logic [31:0] redirect_pc;
    logic        dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    trap_unit dut (
        .clk(clk), .reset(reset), .instr_valid_mem(instr_valid_mem), .pc_mem(pc_mem),
        .ecall_mem(ecall_mem), .ebreak_mem(ebreak_mem), .illegal_mem(illegal_mem),
        .mret_mem(mret_mem), .timer_irq(timer_irq), .ext_irq(ext_irq),
        .stall_pipl(stall_pipl), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trap_taken(trap_taken),
        .mret_exec(mret_exec), .redirect_pc(redirect_pc), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference model: architectural CSR values held as full 32-bit words.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    bit          m_settle;
    logic        ext_q[$];
    logic        e_trap, e_mret;
    logic [31:0] e_cause, e_epc, e_redir, e_rdata;
    logic        s_trap, s_mret;
    logic [31:0] s_redir, s_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0;
        m_mtvec   = 32'h100;
        m_settle  = 0;
        ext_q     = {1'b0, 1'b0};
    endtask

    task automatic model_eval();
        e_trap = 0; e_mret = 0; e_cause = 0; e_epc = 0;
        if (!m_settle && !stall_pipl && instr_valid_mem) begin
            if (illegal_mem)     begin e_trap = 1; e_cause = 2;  e_epc = pc_mem; end
            else if (ecall_mem)  begin e_trap = 1; e_cause = 11; e_epc = pc_mem; end
            else if (ebreak_mem) begin e_trap = 1; e_cause = 3;  e_epc = pc_mem; end
            else if (mret_mem)   e_mret = 1;
            else if (m_mstatus[3] && m_mie[11] && ext_q[0]) begin
                e_trap = 1; e_cause = 32'h8000_000B; e_epc = pc_mem + 4;
            end else if (m_mstatus[3] && m_mie[7] && timer_irq) begin
                e_trap = 1; e_cause = 32'h8000_0007; e_epc = pc_mem + 4;
            end
        end
        e_redir = e_trap ? m_mtvec : (e_mret ? m_mepc : 32'h0);
        e_rdata = m_read(csr_addr);
    endtask

    task automatic model_commit();
        logic [31:0] old_ms;
        old_ms = m_mstatus;
        if (csr_we) begin
            case (csr_addr)
                12'h300: m_mstatus = csr_wdata & 32'h88;
                12'h304: m_mie     = csr_wdata & 32'h880;
                12'h305: m_mtvec   = csr_wdata & ~32'h3;
                12'h341: m_mepc    = csr_wdata & ~32'h3;
                12'h342: m_mcause  = csr_wdata;
                default: ;
            endcase
        end
        if (e_trap) begin
            m_mepc    = e_epc & ~32'h3;
            m_mcause  = e_cause;
            m_mstatus = old_ms[3] ? 32'h80 : 32'h0;
        end else if (e_mret) begin
            m_mstatus = 32'h80 | (old_ms[7] ? 32'h8 : 32'h0);
        end
        if (e_trap || e_mret) m_settle = 1;
        else if (!stall_pipl)  m_settle = 0;
        ext_q.push_back(ext_irq);
        void'(ext_q.pop_front());
    endtask

    // Called just after a rising edge with inputs already set.
    task automatic step();
        #2;
        model_eval();
        s_trap = trap_taken; s_mret = mret_exec; s_redir = redirect_pc; s_rdata = csr_rdata;
        chk("trap_taken", {31'h0, trap_taken}, {31'h0, e_trap});
        chk("mret_exec", {31'h0, mret_exec}, {31'h0, e_mret});
        chk("redirect_pc", redirect_pc, e_redir);
        chk("csr_rdata", csr_rdata, e_rdata);
        chk("excl", {31'h0, trap_taken & mret_exec}, 32'h0);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        instr_valid_mem = 0; pc_mem = 0;
        ecall_mem = 0; ebreak_mem = 0; illegal_mem = 0; mret_mem = 0;
        timer_irq = 0; ext_irq = 0; stall_pipl = 0;
        csr_we = 0; csr_addr = 12'h0; csr_wdata = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        idle(); csr_we = 1; csr_addr = a; csr_wdata = d;
        step();
    endtask

    task automatic csr_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
        idle(); csr_addr = a;
        step();
        chk(tag, s_rdata, exp);
    endtask

    logic [11:0] addr_tab[6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h7C0};

    initial begin
        idle();
        reset = 1;
        instr_valid_mem = 1; illegal_mem = 1; mret_mem = 1; csr_addr = 12'h305;
        #2;
        chk("rst_trap", {31'h0, trap_taken}, 32'h0);
        chk("rst_mret", {31'h0, mret_exec}, 32'h0);
        chk("rst_redir", redirect_pc, 32'h0);
        chk("rst_mtvec", csr_rdata, 32'h100);
        @(posedge clk); #1;
        reset = 0;
        model_reset();

        // Illegal instruction right after reset
        idle(); instr_valid_mem = 1; pc_mem = 32'h40; illegal_mem = 1;
        step();
        chk("ill_trap", {31'h0, s_trap}, 32'h1);
        chk("ill_vec", s_redir, 32'h100);
        idle(); instr_valid_mem = 1; pc_mem = 32'h40; illegal_mem = 1; csr_addr = 12'h341;
        step();
        chk("ill_settle", {31'h0, s_trap}, 32'h0);
        chk("ill_mepc", s_rdata, 32'h40);
        csr_read("ill_mcause", 12'h342, 32'd2);

        // External interrupt through the synchronizer
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h800);
        for (int i = 0; i < 3; i++) begin
            idle(); instr_valid_mem = 1; pc_mem = 32'h200; ext_irq = 1;
            step();
            chk($sformatf("ext_cyc%0d", i), {31'h0, s_trap}, (i == 2) ? 32'h1 : 32'h0);
        end
        csr_read("ext_mcause", 12'h342, 32'h8000_000B);
        csr_read("ext_mepc", 12'h341, 32'h204);
        csr_read("ext_mstatus", 12'h300, 32'h80);

        // mret back
        idle(); instr_valid_mem = 1; mret_mem = 1;
        step();
        chk("mret_exec", {31'h0, s_mret}, 32'h1);
        chk("mret_pc", s_redir, 32'h204);
        csr_read("mret_mstatus", 12'h300, 32'h88);

        // ecall held under stall
        for (int i = 0; i < 4; i++) begin
            idle(); instr_valid_mem = 1; pc_mem = 32'h300; ecall_mem = 1; stall_pipl = (i < 3);
            step();
            chk($sformatf("stall_cyc%0d", i), {31'h0, s_trap}, (i == 3) ? 32'h1 : 32'h0);
        end
        csr_read("ecall_mcause", 12'h342, 32'd11);

        // Trap beats same-cycle mepc write; mtvec write alongside a trap lands
        idle(); instr_valid_mem = 1; pc_mem = 32'h500; ebreak_mem = 1;
        csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'hDEAD_BEEC;
        step();
        csr_read("ebrk_mepc", 12'h341, 32'h500);
        idle(); instr_valid_mem = 1; pc_mem = 32'h500; ebreak_mem = 1;
        csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h403;
        step();
        csr_read("ebrk_mtvec", 12'h305, 32'h400);
        csr_read("ebrk_mcause", 12'h342, 32'd3);

        // Back-to-back ecall
        for (int i = 0; i < 3; i++) begin
            idle(); instr_valid_mem = 1; pc_mem = 32'h600; ecall_mem = 1;
            step();
            chk($sformatf("b2b_cyc%0d", i), {31'h0, s_trap}, (i == 1) ? 32'h0 : 32'h1);
        end

        // Reset while frozen in SETTLE must return to RUN
        idle(); instr_valid_mem = 1; ecall_mem = 1; stall_pipl = 1;
        reset = 1;
        #2;
        chk("rst_settle_trap", {31'h0, trap_taken}, 32'h0);
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        idle(); instr_valid_mem = 1; pc_mem = 32'h700; ecall_mem = 1;
        step();
        chk("rst_settle_run", {31'h0, s_trap}, 32'h1);

        // Random traffic
        csr_write(12'h304, 32'h880);
        csr_write(12'h300, 32'h8);
        for (int n = 0; n < 600; n++) begin
            logic tmr_keep, ext_keep;
            tmr_keep = timer_irq; ext_keep = ext_irq;
            idle();
            instr_valid_mem = ($urandom_range(0, 9) < 8);
            pc_mem      = $urandom & ~32'h3;
            illegal_mem = ($urandom_range(0, 15) == 0);
            ecall_mem   = ($urandom_range(0, 11) == 0);
            ebreak_mem  = ($urandom_range(0, 11) == 0);
            mret_mem    = ($urandom_range(0, 7) == 0);
            timer_irq   = ($urandom_range(0, 5) == 0) ? ~tmr_keep : tmr_keep;
            ext_irq     = ($urandom_range(0, 5) == 0) ? ~ext_keep : ext_keep;
            stall_pipl  = ($urandom_range(0, 4) == 0);
            csr_we      = ($urandom_range(0, 3) == 0);
            csr_addr    = addr_tab[$urandom_range(0, 5)];
            csr_wdata   = $urandom;
            if (csr_we && csr_addr == 12'h300 && $urandom_range(0, 3) != 0)
                csr_wdata = csr_wdata | 32'h8;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
